// File: rtl/dmem_arb_pkg.sv
// Shared types for the Data_Memory arbiter: FSM states, requester ids, default depth.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int ADDR_WORDS_DEF = 32;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-request picker for the Data_Memory arbiter; optional round-robin pointer.
// Latency: combinational grant; pointer (if present) updates on the grant edge.
// Backpressure: none here; a loser simply keeps its level request pending.
//
// Ports: CLK, Reset (sync, active-low), c_req/d_req (requests), take (grant is
// being accepted this cycle), gnt_id (REQ_CPU/REQ_DBG), gnt_vld (any request).
// Build option: DMEM_ARB_RR_EN selects round-robin; otherwise CPU has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic CLK,
  input  logic Reset,
  input  logic c_req,
  input  logic d_req,
  input  logic take,
  output logic gnt_id,
  output logic gnt_vld
);

  assign gnt_vld = c_req | d_req;

`ifdef DMEM_ARB_RR_EN
  // Last port granted; starts at debug so the CPU wins the first conflict.
  logic last_id;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      last_id <= REQ_DBG;
    end else if (take && gnt_vld) begin
      last_id <= gnt_id;
    end
  end

  always_comb begin
    gnt_id = REQ_CPU;
    if (c_req && d_req) begin
      gnt_id = (last_id == REQ_DBG) ? REQ_CPU : REQ_DBG;
    end else if (d_req) begin
      gnt_id = REQ_DBG;
    end
  end
`else
  // Fixed priority keeps no state, so the clock/reset/take inputs go unused.
  logic unused_pick;
  assign unused_pick = ^{CLK, Reset, take};

  always_comb begin
    gnt_id = REQ_CPU;
    if (!c_req && d_req) begin
      gnt_id = REQ_DBG;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port Data_Memory between the CPU MEM stage and a debug/loader port.
// Latency: request sampled in IDLE cycle N, memory access N+1, ack pulse N+2 (3 cycles/txn).
// Backpressure: level requests are held until ack; the loser stays pending for the next txn.
//
// Ports: CLK, Reset (sync, active-low); c_/d_ req, we, addr, wdata (requests);
// c_/d_ ack, err, rdata (responses); MemRead, MemWrite, DataAddr, writeData,
// readData (memory side). Build option: DMEM_ARB_RR_EN (round-robin picker).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WORDS = ADDR_WORDS_DEF
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        c_ack,
  output logic        c_err,
  output logic [31:0] c_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] DataAddr,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  localparam logic [31:0] ADDR_LIM = 32'(ADDR_WORDS);

  arb_state_t  state, state_nxt;
  logic        gnt_id, gnt_vld, take;

  // Latched transaction
  logic        txn_id, txn_we, txn_inr;
  logic [31:0] txn_addr, txn_wdata;

  // Winner's request fields
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [31:0] rd_val;

  dmem_arb_pick u_pick (
    .CLK     (CLK),
    .Reset   (Reset),
    .c_req   (c_req),
    .d_req   (d_req),
    .take    (take),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  assign take      = (state == IDLE) && gnt_vld;
  assign sel_we    = (gnt_id == REQ_DBG) ? d_we    : c_we;
  assign sel_addr  = (gnt_id == REQ_DBG) ? d_addr  : c_addr;
  assign sel_wdata = (gnt_id == REQ_DBG) ? d_wdata : c_wdata;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    DataAddr  = '0;
    writeData = '0;
    rd_val    = '0;
    case (state)
      IDLE: begin
        if (gnt_vld) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt = RESP;
        // Reset gating keeps a reset landing mid-access from committing a write.
        if (txn_inr && Reset) begin
          MemRead   = !txn_we;
          MemWrite  = txn_we;
          DataAddr  = txn_addr;
          writeData = txn_wdata;
        end
        if (txn_inr && !txn_we) rd_val = readData;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      txn_id    <= REQ_CPU;
      txn_we    <= 1'b0;
      txn_inr   <= 1'b0;
      txn_addr  <= '0;
      txn_wdata <= '0;
    end else if (take) begin
      txn_id    <= gnt_id;
      txn_we    <= sel_we;
      txn_inr   <= (sel_addr < ADDR_LIM);
      txn_addr  <= sel_addr;
      txn_wdata <= sel_wdata;
    end
  end

  // Response registers are loaded at the end of ACCESS so they are visible
  // for exactly the RESP cycle, then cleared again.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      c_ack   <= 1'b0;
      c_err   <= 1'b0;
      c_rdata <= '0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      d_rdata <= '0;
    end else if (state == ACCESS) begin
      c_ack   <= (txn_id == REQ_CPU);
      c_err   <= (txn_id == REQ_CPU) && !txn_inr;
      c_rdata <= (txn_id == REQ_CPU) ? rd_val : '0;
      d_ack   <= (txn_id == REQ_DBG);
      d_err   <= (txn_id == REQ_DBG) && !txn_inr;
      d_rdata <= (txn_id == REQ_DBG) ? rd_val : '0;
    end else begin
      c_ack   <= 1'b0;
      c_err   <= 1'b0;
      c_rdata <= '0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      d_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-wide big-endian memory device, transaction-level
// reference model (word array + "arbiter free three cycles after a grant" rule),
// directed scenarios followed by randomized requesters.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_ack, c_err, d_ack, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] DataAddr, writeData;
  wire  [31:0] readData;

  always #5 CLK = ~CLK;

  dmem_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .DataAddr(DataAddr),
    .writeData(writeData), .readData(readData)
  );

  // ---------------- memory device (bytes, big-endian) ----------------
  logic [7:0] ram_b [0:127];
  logic [4:0] ra;
  assign ra = DataAddr[4:0];
  assign readData = (MemRead && DataAddr < 32) ?
                    {ram_b[{ra, 2'd0}], ram_b[{ra, 2'd1}], ram_b[{ra, 2'd2}], ram_b[{ra, 2'd3}]} :
                    32'hzzzz_zzzz;
  always @(posedge CLK) begin
    if (MemWrite && DataAddr < 32) begin
      ram_b[{ra, 2'd0}] <= writeData[31:24];
      ram_b[{ra, 2'd1}] <= writeData[23:16];
      ram_b[{ra, 2'd2}] <= writeData[15:8];
      ram_b[{ra, 2'd3}] <= writeData[7:0];
    end
  end

  function automatic logic [31:0] init_word(int i);
    return 32'h0F00_0000 ^ (32'(i) * 32'h0102_0304);
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] mmem [0:31];
  bit          busy;
  int          g_cyc;
  int          k;
  bit          m_id, m_we, m_inr;
  logic [31:0] m_addr, m_wdata;
  bit          last_g;
  bit          c_done, d_done;
  int          n_chk, n_pass;
  int          n_cack, n_dack, n_both, n_mw;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %h expected %h", tag, k, got, exp);
  endtask

  // One clock cycle: inputs for this cycle are already driven (CLK low).
  task automatic step();
    logic        e_mr, e_mw, e_cack, e_dack, e_cerr, e_derr;
    logic [31:0] e_da, e_wd, e_crd, e_drd, e_rd;
    bit          w;
    #1;
    c_done = 0; d_done = 0;
    e_mr = 0; e_mw = 0; e_da = 0; e_wd = 0;
    e_cack = 0; e_dack = 0; e_cerr = 0; e_derr = 0; e_crd = 0; e_drd = 0;
    // A reset during the access cycle throws the transaction away.
    if (busy && k == g_cyc + 1 && !Reset) busy = 0;
    if (busy && k == g_cyc + 1 && m_inr) begin
      e_mr = !m_we; e_mw = m_we; e_da = m_addr; e_wd = m_wdata;
    end
    if (busy && k == g_cyc + 2) begin
      e_rd = (m_inr && !m_we) ? mmem[m_addr[4:0]] : 32'h0;
      if (m_id) begin e_dack = 1; e_derr = !m_inr; e_drd = e_rd; d_done = 1; end
      else      begin e_cack = 1; e_cerr = !m_inr; e_crd = e_rd; c_done = 1; end
    end
    check_eq("c_ack", c_ack, e_cack);
    check_eq("d_ack", d_ack, e_dack);
    check_eq("c_err", c_err, e_cerr);
    check_eq("d_err", d_err, e_derr);
    check_eq("c_rdata", c_rdata, e_crd);
    check_eq("d_rdata", d_rdata, e_drd);
    check_eq("MemRead", MemRead, e_mr);
    check_eq("MemWrite", MemWrite, e_mw);
    check_eq("DataAddr", DataAddr, e_da);
    check_eq("writeData", writeData, e_wd);
    n_cack += int'(c_ack === 1'b1);
    n_dack += int'(d_ack === 1'b1);
    n_both += int'((c_ack & d_ack) === 1'b1);
    n_mw   += int'(MemWrite === 1'b1);
    if (busy && k == g_cyc + 1 && m_inr && m_we) mmem[m_addr[4:0]] = m_wdata;
    if (!Reset) begin
      last_g = 1;  // pointer restarts at "debug"
    end else if ((!busy || k >= g_cyc + 3) && (c_req || d_req)) begin
`ifdef DMEM_ARB_RR_EN
      w = (c_req && d_req) ? !last_g : d_req;
`else
      w = !c_req;
`endif
      last_g  = w;
      busy    = 1;
      g_cyc   = k;
      m_id    = w;
      m_we    = w ? d_we : c_we;
      m_addr  = w ? d_addr : c_addr;
      m_wdata = w ? d_wdata : c_wdata;
      m_inr   = (m_addr < 32);
    end
    @(posedge CLK);
    @(negedge CLK);
    k++;
  endtask

  task automatic set_c(input bit we, input logic [31:0] a, input logic [31:0] wd);
    c_req = 1; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic set_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  // Run until every raised request has completed, dropping each on its ack.
  task automatic wait_all(input string tag, input int budget);
    bit c_pend, d_pend;
    c_pend = c_req; d_pend = d_req;
    for (int i = 0; i < budget && (c_pend || d_pend); i++) begin
      step();
      if (c_done) begin c_pend = 0; c_req = 0; end
      if (d_done) begin d_pend = 0; d_req = 0; end
    end
    check_eq({tag, "_pending"}, {30'd0, c_pend, d_pend}, 32'd0);
    c_req = 0; d_req = 0;
  endtask

  initial begin
    int c0, d0, mw0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] v;
      v = init_word(i);
      mmem[i] = v;
      ram_b[4*i] = v[31:24]; ram_b[4*i+1] = v[23:16];
      ram_b[4*i+2] = v[15:8]; ram_b[4*i+3] = v[7:0];
    end
    n_chk = 0; n_pass = 0; n_cack = 0; n_dack = 0; n_both = 0; n_mw = 0;
    busy = 0; g_cyc = 0; k = 0; last_g = 1;
    m_id = 0; m_we = 0; m_inr = 0; m_addr = 0; m_wdata = 0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

    // Reset held two cycles with a CPU request up: nothing may respond.
    Reset = 0;
    set_c(0, 32'd2, 32'd0);
    @(negedge CLK);
    step(); step();
    Reset = 1;
    wait_all("rst_release", 10);

    // Write then read back word 5.
    set_c(1, 32'd5, 32'hDEADBEEF);
    wait_all("wr5", 10);
    set_c(0, 32'd5, 32'd0);
    wait_all("rd5", 10);

    // Out-of-range debug read.
    set_d(0, 32'd40, 32'd0);
    wait_all("rd40", 10);

    // Both ports held for four transactions.
    c0 = n_cack; d0 = n_dack;
    set_c(0, 32'd1, 32'd0);
    set_d(0, 32'd2, 32'd0);
    for (int i = 0; i < 12; i++) step();
    c_req = 0; d_req = 0;
`ifdef DMEM_ARB_RR_EN
    check_eq("held_c_acks", n_cack - c0, 32'd2);
    check_eq("held_d_acks", n_dack - d0, 32'd2);
`else
    check_eq("held_c_acks", n_cack - c0, 32'd4);
    check_eq("held_d_acks", n_dack - d0, 32'd0);
`endif
    for (int i = 0; i < 3; i++) step();

    // Reset lands in the ACCESS cycle of a write to word 3.
    c0 = n_cack; mw0 = n_mw;
    set_c(1, 32'd3, 32'h11223344);
    step();
    Reset = 0; c_req = 0;
    step();
    Reset = 1;
    step(); step();
    check_eq("rst_acc_acks", n_cack - c0, 32'd0);
    check_eq("rst_acc_writes", n_mw - mw0, 32'd0);
    set_c(0, 32'd3, 32'd0);
    wait_all("rd3", 10);

    // Simultaneous writes, then debug reads its word back.
    set_c(1, 32'd9, 32'h0BADF00D);
    set_d(1, 32'd7, 32'hA5A5A5A5);
    wait_all("dual_wr", 12);
    set_d(0, 32'd7, 32'd0);
    wait_all("rd7", 10);

    // Randomized requesters.
    for (int i = 0; i < 600; i++) begin
      if (!c_req && $urandom_range(0, 2) == 0)
        set_c(1'($urandom_range(0, 1)), 32'($urandom_range(0, 39)), $urandom);
      if (!d_req && $urandom_range(0, 2) == 0)
        set_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 39)), $urandom);
      step();
      if (c_done) c_req = 0;
      if (d_done) d_req = 0;
    end
    c_req = 0; d_req = 0;
    for (int i = 0; i < 4; i++) step();

    check_eq("acks_same_cycle", n_both, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
